// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared definitions for the ysyx_23060184 load/store unit: access size
// encodings, bus response codes, FSM state encoding and small helpers used
// by the LSU top and the lane-alignment block.
package ysyx_23060184_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } state_t;

  // A doubleword access on a 32-bit bus degrades to a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size, input int data_width);
    return (data_width == 32 && size == SIZE_D) ? SIZE_W : size;
  endfunction

  function automatic logic misaligned(input logic [2:0] low, input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SIZE_B:  mask = 3'b000;
      SIZE_H:  mask = 3'b001;
      SIZE_W:  mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return |(low & mask);
  endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_if.sv
// AXI4-Lite style memory bus between the LSU (master) and memory (slave).
// Channels: AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready),
// AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready).
interface ysyx_23060184_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/ysyx_23060184_lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
//   offset/size/load_unsigned : byte offset inside the bus word and access size
//   rdata -> load_data        : shift right to lane 0, sign/zero extend
//   store_data -> wdata/wstrb : shift left to the target lane, byte strobes
// Lanes that fall past the bus word are dropped (no split access).
module ysyx_23060184_lsu_align
  import ysyx_23060184_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(STRB_WIDTH)
) (
  input  logic [OFF_W-1:0]      offset,
  input  logic [1:0]            size,
  input  logic                  load_unsigned,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb
);
  logic [1:0]            sz;
  logic [DATA_WIDTH-1:0] rshift;
  logic [STRB_WIDTH-1:0] lane_mask;
  logic                  sbit;
  logic                  fill;
  int                    nbits;

  always_comb begin
    sz     = eff_size(size, DATA_WIDTH);
    rshift = rdata >> {offset, 3'b000};
    case (sz)
      SIZE_B: begin
        nbits = 8;  sbit = rshift[7];  lane_mask = STRB_WIDTH'(1);
      end
      SIZE_H: begin
        nbits = 16; sbit = rshift[15]; lane_mask = STRB_WIDTH'(3);
      end
      SIZE_W: begin
        nbits = 32; sbit = rshift[31]; lane_mask = STRB_WIDTH'(15);
      end
      default: begin
        nbits = DATA_WIDTH; sbit = rshift[DATA_WIDTH-1]; lane_mask = '1;
      end
    endcase
    fill      = sbit & ~load_unsigned;
    load_data = rshift;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= nbits) load_data[i] = fill;
    end
    wdata = store_data << {offset, 3'b000};
    wstrb = lane_mask << offset;
  end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// ysyx_23060184 load/store unit: accepts one request from execute, runs it
// on the AXI4-Lite style bus and presents the result to writeback.
//   clk, resetn (async, active low)
//   in_valid/in_ready, mem_read, mem_write, size, load_unsigned, addr,
//   store_data                         : request from execute
//   out_valid/out_ready, load_data, bus_err : result to writeback
//   bus (master modport)               : AR/R/AW/W/B channels
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned memory requests
// complete immediately with bus_err=1 and no bus traffic. Without it they
// are issued as-is and lanes past the word boundary are truncated.
module ysyx_23060184_lsu
  import ysyx_23060184_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  load_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  bus_err,
  ysyx_23060184_lsu_if.master   bus
);
  localparam int OFF_W = $clog2(STRB_WIDTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [DATA_WIDTH-1:0] sdata_q;
  logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [1:0]            size_eff;
  logic [DATA_WIDTH-1:0] ld_ext, wdata_al;
  logic [STRB_WIDTH-1:0] wstrb_al;
  logic                  aw_done, w_done;

  assign size_eff = eff_size(size, DATA_WIDTH);

`ifdef LSU_MISALIGN_CHECK_EN
  logic bad_align;
  assign bad_align = (mem_read || mem_write) && misaligned(addr[2:0], size_eff);
`endif

  ysyx_23060184_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .offset        (addr_q[OFF_W-1:0]),
    .size          (size_q),
    .load_unsigned (unsigned_q),
    .rdata         (bus.rdata),
    .store_data    (sdata_q),
    .load_data     (ld_ext),
    .wdata         (wdata_al),
    .wstrb         (wstrb_al)
  );

  assign bus.araddr  = addr_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.awaddr  = addr_q;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_al;
  assign bus.wstrb   = wstrb_al;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

  // A write channel counts as finished once its valid has dropped or it
  // handshakes this cycle; AW and W may complete in either order.
  assign aw_done = !awvalid_q || bus.awready;
  assign w_done  = !wvalid_q  || bus.wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      load_data  <= '0;
      bus_err    <= 1'b0;
      addr_q     <= '0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      sdata_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            addr_q     <= addr;
            size_q     <= size_eff;
            unsigned_q <= load_unsigned;
            sdata_q    <= store_data;
            in_ready   <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            if (bad_align) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              load_data <= '0;
              bus_err   <= 1'b1;
            end else
`endif
            if (mem_read) begin
              state     <= S_RD_ADDR;
              arvalid_q <= 1'b1;
            end else if (mem_write) begin
              state     <= S_WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              load_data <= '0;
              bus_err   <= 1'b0;
            end
          end
        end
        S_RD_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (bus.rvalid) begin
            rready_q  <= 1'b0;
            load_data <= ld_ext;
            bus_err   <= (bus.rresp != RESP_OKAY);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_WR_REQ: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bus.bvalid) begin
            bready_q  <= 1'b0;
            load_data <= '0;
            bus_err   <= (bus.bresp != RESP_OKAY);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed bench for ysyx_23060184_lsu (DATA_WIDTH=32). The memory model
// asserts each ready a programmable number of cycles after seeing valid
// (1 = next cycle) and returns R/B one cycle after the address/data
// handshakes, so a zero-wait access completes 4 cycles after accept.
module tb_ysyx_23060184_lsu;
  import ysyx_23060184_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        load_unsigned = 1'b0, out_ready = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic        in_ready, out_valid, bus_err;
  logic [31:0] load_data;

  int checks = 0;
  int failures = 0;

  ysyx_23060184_lsu_if bus ();

  ysyx_23060184_lsu dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned),
    .addr(addr), .store_data(store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .load_data(load_data), .bus_err(bus_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] rd_value = 32'h0;
  logic [1:0]  rd_resp = 2'b00, wr_resp = 2'b00;
  int          ar_lat = 1, aw_lat = 1, w_lat = 1;
  int          ar_cnt, aw_cnt, w_cnt;
  logic        got_aw, got_w;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        aw_hs_now, w_hs_now;

  assign aw_hs_now = bus.awvalid && bus.awready;
  assign w_hs_now  = bus.wvalid && bus.wready;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
      bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
    end else begin
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.arready <= 1'b0; ar_cnt <= 0; cap_araddr <= bus.araddr;
        bus.rvalid <= 1'b1; bus.rdata <= rd_value; bus.rresp <= rd_resp;
      end else if (bus.arvalid) begin
        if (ar_cnt + 1 >= ar_lat) bus.arready <= 1'b1;
        ar_cnt <= ar_cnt + 1;
      end
      if (aw_hs_now) begin
        bus.awready <= 1'b0; aw_cnt <= 0; cap_awaddr <= bus.awaddr;
      end else if (bus.awvalid) begin
        if (aw_cnt + 1 >= aw_lat) bus.awready <= 1'b1;
        aw_cnt <= aw_cnt + 1;
      end
      if (w_hs_now) begin
        bus.wready <= 1'b0; w_cnt <= 0; cap_wdata <= bus.wdata; cap_wstrb <= bus.wstrb;
      end else if (bus.wvalid) begin
        if (w_cnt + 1 >= w_lat) bus.wready <= 1'b1;
        w_cnt <= w_cnt + 1;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if ((got_aw || aw_hs_now) && (got_w || w_hs_now)) begin
        bus.bvalid <= 1'b1; bus.bresp <= wr_resp; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        if (aw_hs_now) got_aw <= 1'b1;
        if (w_hs_now)  got_w  <= 1'b1;
      end
    end
  end

  // ---------------- bus monitors ----------------
  int   ar_hs = 0, aw_hs = 0, w_hs = 0, bready_rise = 0;
  logic bready_d = 1'b0;
  logic split_seen = 1'b0;

  always @(posedge clk) begin
    if (bus.arvalid && bus.arready) ar_hs++;
    if (aw_hs_now) aw_hs++;
    if (w_hs_now) w_hs++;
    if (bus.bready && !bready_d) bready_rise++;
    bready_d = bus.bready;
  end

  always @(negedge clk) begin
    if (!bus.awvalid && bus.wvalid) split_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  // Presents one request, then returns the number of clock edges from the
  // accepting edge until out_valid is seen (1 = next cycle, 0 = timeout).
  task automatic do_request(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic lu, input logic [31:0] a, input logic [31:0] sd,
                            output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    in_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz;
    load_unsigned = lu; addr = a; store_data = sd;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      addr = 32'h0; store_data = 32'h0; load_unsigned = 1'b0;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({out_valid, bus_err} !== 2'b00) begin failures++; $display("FAIL reset_outputs got=%b exp=00", {out_valid, bus_err}); end
    checks++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin failures++; $display("FAIL reset_bus_valids got=%b exp=00000", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
    checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    int lat, ar0;
    rd_value = 32'hDEAD_BEEF; rd_resp = RESP_OKAY; ar0 = ar_hs;
    do_request(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8000_0004, 32'h0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL load_word_latency got=%0d exp=4", lat); end
    checks++; if (load_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_word_data got=%h exp=deadbeef", load_data); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL load_word_err got=%b exp=0", bus_err); end
    checks++; if (cap_araddr !== 32'h8000_0004) begin failures++; $display("FAIL load_word_araddr got=%h exp=80000004", cap_araddr); end
    checks++; if (ar_hs - ar0 !== 1) begin failures++; $display("FAIL load_word_ar_count got=%0d exp=1", ar_hs - ar0); end
    take_result();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL load_word_release got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_load_byte_half();
    int lat;
    rd_value = 32'h8012_3456;
    do_request(1'b1, 1'b0, SIZE_B, 1'b0, 32'h8000_0003, 32'h0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL lb_latency got=%0d exp=4", lat); end
    checks++; if (load_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", load_data); end
    take_result();
    do_request(1'b1, 1'b0, SIZE_B, 1'b1, 32'h8000_0003, 32'h0, lat);
    checks++; if (load_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_unsigned got=%h exp=00000080", load_data); end
    take_result();
    rd_value = 32'hABCD_1234;
    do_request(1'b1, 1'b0, SIZE_H, 1'b0, 32'h8000_0002, 32'h0, lat);
    checks++; if (load_data !== 32'hFFFF_ABCD) begin failures++; $display("FAIL lh_signed got=%h exp=ffffabcd", load_data); end
    take_result();
  endtask

  task automatic test_store_half_split();
    int lat, br0, aw0, w0;
    aw_lat = 1; w_lat = 4; wr_resp = RESP_OKAY;
    br0 = bready_rise; aw0 = aw_hs; w0 = w_hs; split_seen = 1'b0;
    do_request(1'b0, 1'b1, SIZE_H, 1'b0, 32'h8000_0002, 32'hFFFF_1234, lat);
    checks++; if (lat !== 7) begin failures++; $display("FAIL sh_latency got=%0d exp=7", lat); end
    checks++; if (cap_wdata[31:16] !== 16'h1234) begin failures++; $display("FAIL sh_wdata got=%h exp=1234xxxx", cap_wdata); end
    checks++; if (cap_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_wstrb got=%b exp=1100", cap_wstrb); end
    checks++; if (cap_awaddr !== 32'h8000_0002) begin failures++; $display("FAIL sh_awaddr got=%h exp=80000002", cap_awaddr); end
    checks++; if (split_seen !== 1'b1) begin failures++; $display("FAIL sh_awvalid_dropped_first got=%b exp=1", split_seen); end
    checks++; if (bready_rise - br0 !== 1) begin failures++; $display("FAIL sh_wr_resp_entries got=%0d exp=1", bready_rise - br0); end
    checks++; if ({aw_hs - aw0, w_hs - w0} !== {32'd1, 32'd1}) begin failures++; $display("FAIL sh_handshakes got aw=%0d w=%0d exp 1/1", aw_hs - aw0, w_hs - w0); end
    checks++; if ({bus_err, load_data} !== 33'h0) begin failures++; $display("FAIL sh_result got err=%b data=%h exp 0/0", bus_err, load_data); end
    w_lat = 1;
    take_result();
  endtask

  task automatic test_store_error_hold();
    int lat;
    wr_resp = RESP_SLVERR;
    do_request(1'b0, 1'b1, SIZE_W, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL sw_latency got=%0d exp=4", lat); end
    checks++; if ({cap_wdata, cap_wstrb} !== {32'hCAFE_F00D, 4'hF}) begin failures++; $display("FAIL sw_wdata_wstrb got=%h/%b exp=cafef00d/1111", cap_wdata, cap_wstrb); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL sw_bus_err got=%b exp=1", bus_err); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, bus_err, in_ready, load_data} !== {3'b110, 32'h0}) begin
        failures++;
        $display("FAIL sw_hold_cycle%0d got valid=%b err=%b in_ready=%b data=%h exp 1/1/0/0", i, out_valid, bus_err, in_ready, load_data);
      end
    end
    take_result();
    wr_resp = RESP_OKAY;
  endtask

  task automatic test_store_byte();
    int lat;
    do_request(1'b0, 1'b1, SIZE_B, 1'b0, 32'h8000_0001, 32'h1234_56A5, lat);
    checks++; if (cap_wdata !== 32'h3456_A500) begin failures++; $display("FAIL sb_wdata got=%h exp=3456a500", cap_wdata); end
    checks++; if (cap_wstrb !== 4'b0010) begin failures++; $display("FAIL sb_wstrb got=%b exp=0010", cap_wstrb); end
    take_result();
  endtask

  task automatic test_load_error_then_nonmem();
    int lat, ar0, aw0;
    rd_value = 32'h0000_00FF; rd_resp = RESP_DECERR;
    do_request(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8000_0020, 32'h0, lat);
    checks++; if ({bus_err, load_data} !== {1'b1, 32'h0000_00FF}) begin failures++; $display("FAIL lw_decerr got err=%b data=%h exp 1/000000ff", bus_err, load_data); end
    take_result();
    rd_resp = RESP_OKAY;
    ar0 = ar_hs; aw0 = aw_hs;
    do_request(1'b0, 1'b0, SIZE_W, 1'b0, 32'h8000_0030, 32'h5555_5555, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL nonmem_latency got=%0d exp=1", lat); end
    checks++; if ({bus_err, load_data} !== 33'h0) begin failures++; $display("FAIL nonmem_result got err=%b data=%h exp 0/0", bus_err, load_data); end
    checks++; if ({ar_hs - ar0, aw_hs - aw0} !== 64'h0) begin failures++; $display("FAIL nonmem_bus_traffic got ar=%0d aw=%0d exp 0/0", ar_hs - ar0, aw_hs - aw0); end
    take_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    ar_lat = 20;
    in_valid = 1'b1; mem_read = 1'b1; size = SIZE_W; addr = 32'h8000_0040;
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    checks++; if (bus.arvalid !== 1'b1) begin failures++; $display("FAIL rst_mid_arvalid_before got=%b exp=1", bus.arvalid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({bus.arvalid, bus.rready, out_valid, in_ready} !== 4'b0001) begin failures++; $display("FAIL rst_mid_async got=%b exp=0001", {bus.arvalid, bus.rready, out_valid, in_ready}); end
    ar_lat = 1;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rd_value = 32'h1122_3344;
    do_request(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8000_0010, 32'h0, lat);
    checks++; if ({lat == 4, load_data} !== {1'b1, 32'h1122_3344}) begin failures++; $display("FAIL rst_mid_recover got lat=%0d data=%h exp 4/11223344", lat, load_data); end
    take_result();
  endtask

  task automatic test_misalign();
    int lat, ar0, aw0;
    ar0 = ar_hs; aw0 = aw_hs;
    rd_value = 32'hDEAD_BEEF;
`ifdef LSU_MISALIGN_CHECK_EN
    do_request(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8000_0001, 32'h0, lat);
    checks++; if ({lat == 1, bus_err, load_data} !== {2'b11, 32'h0}) begin failures++; $display("FAIL mis_load got lat=%0d err=%b data=%h exp 1/1/0", lat, bus_err, load_data); end
    take_result();
    do_request(1'b0, 1'b1, SIZE_H, 1'b0, 32'h8000_0003, 32'h0000_BEEF, lat);
    checks++; if ({lat == 1, bus_err} !== 2'b11) begin failures++; $display("FAIL mis_store got lat=%0d err=%b exp 1/1", lat, bus_err); end
    checks++; if ({ar_hs - ar0, aw_hs - aw0} !== 64'h0) begin failures++; $display("FAIL mis_bus_traffic got ar=%0d aw=%0d exp 0/0", ar_hs - ar0, aw_hs - aw0); end
    take_result();
`else
    do_request(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8000_0001, 32'h0, lat);
    checks++; if ({lat == 4, bus_err, load_data} !== {2'b10, 32'h00DE_ADBE}) begin failures++; $display("FAIL mis_load got lat=%0d err=%b data=%h exp 4/0/00deadbe", lat, bus_err, load_data); end
    take_result();
    do_request(1'b0, 1'b1, SIZE_H, 1'b0, 32'h8000_0003, 32'h0000_BEEF, lat);
    checks++; if ({cap_wdata, cap_wstrb} !== {32'hEF00_0000, 4'b1000}) begin failures++; $display("FAIL mis_store got wdata=%h wstrb=%b exp ef000000/1000", cap_wdata, cap_wstrb); end
    checks++; if ({ar_hs - ar0, aw_hs - aw0} !== {32'd1, 32'd1}) begin failures++; $display("FAIL mis_bus_traffic got ar=%0d aw=%0d exp 1/1", ar_hs - ar0, aw_hs - aw0); end
    take_result();
`endif
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte_half();
    test_store_half_split();
    test_store_error_hold();
    test_store_byte();
    test_load_error_then_nonmem();
    test_reset_mid();
    test_misalign();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
